// File: rtl/ekf_cb_pkg.sv
// ============================================================================
// ekf_cb_pkg
//  Shared encoding for the CB port-B direction mapping. The CB write-side
//  mapper and the read-side cb_doutb_map both import this package, so the two
//  ends of the buffer always agree on how a direction is encoded.
//
//  Contents
//   dir_e       2-bit lane direction: IDLE / POS / NEG / NEW
//   DIR_NEW_0/1 values of the NEW-mode half select (l_k_0)
//   cb_tag_t    per-read control tag carried alongside a read in flight
//   dir_active  helper: true for any direction that moves data
// ============================================================================
package ekf_cb_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10,
        DIR_NEW  = 2'b11
    } dir_e;

    // NEW mode moves only half of the lanes; l_k_0 picks which half.
    // DIR_NEW_1 selects input lanes 0/1, DIR_NEW_0 selects input lanes 2/3.
    localparam logic DIR_NEW_0 = 1'b0;
    localparam logic DIR_NEW_1 = 1'b1;

    // Everything needed to interpret one read once its data returns.
    typedef struct packed {
        logic vld;
        dir_e sel;
        logic l_k_0;
    } cb_tag_t;

    function automatic logic dir_active(input dir_e sel);
        return (sel != DIR_IDLE);
    endfunction

endpackage

// File: rtl/cb_doutb_map_if.sv
// ============================================================================
// cb_doutb_map_if
//  Bundles the CB port-B read-side signals of cb_doutb_map.
//
//  Signals
//   CB_rd_en      read issued to CB port B this cycle
//   CB_doutb_sel  direction for this read (dir_e)
//   l_k_0         NEW-mode half select, sampled with CB_rd_en
//   CB_doutb      CB port-B read data, L lanes of RSA_DW bits, lane 0 in LSBs
//   CB_B_din      mapped and skewed lanes towards the RSA, lane 0 in LSBs
//   CB_B_din_vld  per-lane valid aligned with CB_B_din
//
//  Modports
//   master  the side issuing reads and consuming the RSA lanes
//   slave   cb_doutb_map itself
// ============================================================================
interface cb_doutb_map_if #(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 16
);
    import ekf_cb_pkg::*;

    logic                  CB_rd_en;
    dir_e                  CB_doutb_sel;
    logic                  l_k_0;
    logic [L*RSA_DW-1:0]   CB_doutb;
    logic [X*RSA_DW-1:0]   CB_B_din;
    logic [X-1:0]          CB_B_din_vld;

    modport master (
        output CB_rd_en,
        output CB_doutb_sel,
        output l_k_0,
        output CB_doutb,
        input  CB_B_din,
        input  CB_B_din_vld
    );

    modport slave (
        input  CB_rd_en,
        input  CB_doutb_sel,
        input  l_k_0,
        input  CB_doutb,
        output CB_B_din,
        output CB_B_din_vld
    );

endinterface

// File: rtl/lane_skew_sr.sv
// ============================================================================
// lane_skew_sr
//  DEPTH-stage shift register for one RSA lane, carrying data and its valid
//  bit together. The data output is forced to zero whenever the valid bit is
//  low, so the systolic array edge always sees zero padding between items.
//  DEPTH = 0 degenerates to a wire (still with the zero forcing).
//
//  Parameters
//   DW     lane data width
//   DEPTH  number of register stages (0 allowed)
//
//  Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   din       lane data in
//   din_vld   lane valid in
//   dout      lane data out, DEPTH cycles later, zero when dout_vld = 0
//   dout_vld  lane valid out, DEPTH cycles later
// ============================================================================
module lane_skew_sr #(
    parameter int DW    = 16,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld
);

    if (DEPTH == 0) begin : g_wire
        // No skew on this lane: clock and reset are not needed here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign dout_vld = din_vld;
        assign dout     = din_vld ? din : '0;
    end else begin : g_shift
        logic [DW-1:0] sr_data [DEPTH];
        logic          sr_vld  [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < DEPTH; s++) begin
                    sr_data[s] <= '0;
                    sr_vld[s]  <= 1'b0;
                end
            end else begin
                sr_data[0] <= din;
                sr_vld[0]  <= din_vld;
                for (int s = 1; s < DEPTH; s++) begin
                    sr_data[s] <= sr_data[s-1];
                    sr_vld[s]  <= sr_vld[s-1];
                end
            end
        end

        assign dout_vld = sr_vld[DEPTH-1];
        assign dout     = sr_vld[DEPTH-1] ? sr_data[DEPTH-1] : '0;
    end

endmodule

// File: rtl/cb_doutb_map.sv
// ============================================================================
// cb_doutb_map
//  Read-side counterpart of the CB port-B write mapper. Takes CB BRAM port-B
//  read data, undoes the lane direction mapping (POS pass-through, NEG lane
//  reversal, NEW half-select) and applies a per-lane diagonal skew so the data
//  enters the RSA systolic array edge correctly aligned.
//
//  Pipeline
//   control pipe : RD_LAT stages of {vld, sel, l_k_0}; the last stage lines up
//                  with the BRAM data returning for that read
//   map register : 1 stage, applies the direction mapping
//   skew         : lane i delayed by i*SKEW_EN further stages
//  Latency CB_rd_en -> lane i = RD_LAT + 1 + i*SKEW_EN cycles; one read per
//  cycle, no stalls. Data is moved bit-exact, no arithmetic.
//
//  Parameters
//   X        RSA lanes on output, must equal L
//   Y        RSA columns, only checked for sanity
//   L        CB port-B lanes, NEW mode needs L = 4
//   RSA_DW   lane width
//   RD_LAT   CB BRAM read latency, 1..3
//   SKEW_EN  1: diagonal skew, 0: all lanes aligned
//
//  Ports
//   clk        system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        cb_doutb_map_if slave (read control, read data, RSA lanes)
// ============================================================================
module cb_doutb_map
    import ekf_cb_pkg::*;
#(
    parameter int X       = 4,
    parameter int Y       = 4,
    parameter int L       = 4,
    parameter int RSA_DW  = 16,
    parameter int RD_LAT  = 1,
    parameter int SKEW_EN = 1
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    cb_doutb_map_if.slave   bus
);

    // An unsupported configuration never raises a lane valid, so a bad
    // instance shows up as a dead data path rather than garbage in the array.
    localparam bit CFG_OK = (X == L) && (L == 4) && (Y >= 1) &&
                            (RD_LAT >= 1) && (RD_LAT <= 3) &&
                            ((SKEW_EN == 0) || (SKEW_EN == 1));

    // ------------------------------------------------------------------------
    // Reset: asserted asynchronously, released synchronously to clk.
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------------
    // Control pipe. Each read carries its own direction tag, so a change of
    // direction between back-to-back reads cannot disturb reads in flight.
    // The tag leaving the last stage qualifies CB_doutb in that same cycle.
    // ------------------------------------------------------------------------
    cb_tag_t tag_in;
    cb_tag_t tag_pipe [RD_LAT];
    cb_tag_t tag_out;

    always_comb begin
        tag_in       = '0;
        tag_in.vld   = bus.CB_rd_en && dir_active(bus.CB_doutb_sel);
        tag_in.sel   = bus.CB_doutb_sel;
        tag_in.l_k_0 = bus.l_k_0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign tag_out = tag_pipe[RD_LAT-1];

    // ------------------------------------------------------------------------
    // Direction mapping. Every lane defaults to zero/invalid, which also
    // covers IDLE and cycles without a read.
    // ------------------------------------------------------------------------
    logic [RSA_DW-1:0] in_lane    [L];
    logic [RSA_DW-1:0] map_d_next [X];
    logic              map_v_next [X];

    always_comb begin
        for (int k = 0; k < L; k++) begin
            in_lane[k] = bus.CB_doutb[k*RSA_DW +: RSA_DW];
        end
        for (int i = 0; i < X; i++) begin
            map_d_next[i] = '0;
            map_v_next[i] = 1'b0;
        end

        if (tag_out.vld && CFG_OK) begin
            case (tag_out.sel)
                DIR_POS: begin
                    for (int i = 0; i < X; i++) begin
                        map_d_next[i] = in_lane[i];
                        map_v_next[i] = 1'b1;
                    end
                end
                DIR_NEG: begin
                    for (int i = 0; i < X; i++) begin
                        map_d_next[i] = in_lane[L-1-i];
                        map_v_next[i] = 1'b1;
                    end
                end
                DIR_NEW: begin
                    // Only lanes 0/1 carry data; lanes 2/3 stay as padding.
                    case (tag_out.l_k_0)
                        DIR_NEW_1: begin
                            map_d_next[0] = in_lane[0];
                            map_d_next[1] = in_lane[1];
                        end
                        DIR_NEW_0: begin
                            map_d_next[0] = in_lane[2];
                            map_d_next[1] = in_lane[3];
                        end
                    endcase
                    map_v_next[0] = 1'b1;
                    map_v_next[1] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    logic [RSA_DW-1:0] map_d [X];
    logic              map_v [X];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < X; i++) begin
                map_d[i] <= '0;
                map_v[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < X; i++) begin
                map_d[i] <= map_d_next[i];
                map_v[i] <= map_v_next[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Diagonal skew: lane i sits i stages behind lane 0 so that successive
    // elements enter successive array rows on successive cycles.
    // ------------------------------------------------------------------------
    logic [RSA_DW-1:0] lane_d [X];
    logic              lane_v [X];

    for (genvar i = 0; i < X; i++) begin : g_lane
        lane_skew_sr #(
            .DW    (RSA_DW),
            .DEPTH (i * SKEW_EN)
        ) u_skew (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (map_d[i]),
            .din_vld  (map_v[i]),
            .dout     (lane_d[i]),
            .dout_vld (lane_v[i])
        );
    end

    logic [X*RSA_DW-1:0] din_flat;
    logic [X-1:0]        vld_flat;

    always_comb begin
        din_flat = '0;
        vld_flat = '0;
        for (int i = 0; i < X; i++) begin
            din_flat[i*RSA_DW +: RSA_DW] = lane_d[i];
            vld_flat[i]                  = lane_v[i];
        end
    end

    assign bus.CB_B_din     = din_flat;
    assign bus.CB_B_din_vld = vld_flat;

endmodule
